// File: rtl/sqrt_range_reduce_if.sv
// Handshake and data bundle between the log stage, the sqrt range reducer and the sqrt polynomial stage.
// Latency: none, wires only. Backpressure: carries the valid/ready pairs for both sides.
// Both modports are included: master is the upstream/downstream environment, slave is the reducer.
interface sqrt_range_reduce_if;
    logic [30:0] e_i;
    logic        valid_i;
    logic        ready_o;
    logic [30:0] x_f;
    logic        polysel;
    logic [4:0]  exp_f;
    logic        zero_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output e_i, valid_i, ready_i,
        input  ready_o, x_f, polysel, exp_f, zero_o, valid_o
    );

    modport slave (
        input  e_i, valid_i, ready_i,
        output ready_o, x_f, polysel, exp_f, zero_o, valid_o
    );
endinterface

// File: rtl/sqrt_range_reduce.sv
// Range-reduces UQ7.24 e into mantissa fraction, table select and halved exponent for sqrt.
// Latency 2 cycles; full-throughput valid/ready, S2 holds under backpressure. Option: SQRT_RR_ZERO_DET_EN.
module sqrt_range_reduce (
    input  logic               clk,
    input  logic               rst_n,
    sqrt_range_reduce_if.slave bus
);
    logic        s1_vld;
    logic [30:0] s1_e;
    logic [4:0]  s1_p;
    logic        s2_vld;
    logic [30:0] s2_x_f;
    logic        s2_polysel;
    logic [4:0]  s2_exp_f;
    logic        s2_zero;

    logic        s1_load;
    logic        s2_load;
    logic [4:0]  lead_p;
    logic [5:0]  exp_e;
    logic [30:0] x_next;
    logic        is_zero;

    // Leading-one position; an all-zero input falls out as p = 0, same as e = 1.
    always_comb begin
        lead_p = '0;
        for (int i = 0; i < 31; i++) begin
            if (bus.e_i[i]) lead_p = i[4:0];
        end
    end

    assign s2_load     = s1_vld && (!s2_vld || bus.ready_i);
    assign bus.ready_o = !s1_vld || s2_load;
    assign s1_load     = bus.valid_i && bus.ready_o;

    // exp_e = p - 24; the parity of exp_e equals p[0], and an arithmetic
    // halving (drop the LSB) gives floor(exp_e/2) for both parities.
    assign exp_e  = {1'b0, s1_p} - 6'd24;
    assign x_next = s1_e << (5'd31 - s1_p);

`ifdef SQRT_RR_ZERO_DET_EN
    assign is_zero = (s1_e == 31'd0);
`else
    assign is_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_e   <= '0;
            s1_p   <= '0;
        end else if (s1_load) begin
            s1_vld <= 1'b1;
            s1_e   <= bus.e_i;
            s1_p   <= lead_p;
        end else if (s2_load) begin
            s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld     <= 1'b0;
            s2_x_f     <= '0;
            s2_polysel <= 1'b1;
            s2_exp_f   <= '0;
            s2_zero    <= 1'b0;
        end else if (s2_load) begin
            s2_vld <= 1'b1;
            if (is_zero) begin
                s2_x_f     <= '0;
                s2_polysel <= 1'b1;
                s2_exp_f   <= '0;
                s2_zero    <= 1'b1;
            end else begin
                s2_x_f     <= x_next;
                s2_polysel <= ~exp_e[0];
                s2_exp_f   <= exp_e[5:1];
                s2_zero    <= 1'b0;
            end
        end else if (bus.ready_i) begin
            s2_vld <= 1'b0;
        end
    end

    assign bus.valid_o = s2_vld;
    assign bus.x_f     = s2_x_f;
    assign bus.polysel = s2_polysel;
    assign bus.exp_f   = s2_exp_f;
    assign bus.zero_o  = s2_zero;
endmodule
